// File: rtl/seq_div8.sv
// Iterative unsigned restoring divider: Q = A / B, R = A % B, one quotient bit per clock.
// start/done handshake; divide-by-zero completes in one cycle with Q = all ones, R = A.
module seq_div8 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] dq_q, dq_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;

   // Trial subtraction is one bit wider so a divisor above 2^(WIDTH-1) cannot overflow.
   logic [WIDTH:0]   shifted_s;
   logic [WIDTH:0]   diff_s;
   logic             ge_s;

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         dq_q    <= {WIDTH{1'b0}};
         rem_q   <= {WIDTH{1'b0}};
         dvs_q   <= {WIDTH{1'b0}};
         cnt_q   <= {CW{1'b0}};
         quo_q   <= {WIDTH{1'b0}};
         res_q   <= {WIDTH{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dq_q    <= dq_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         res_q   <= res_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   // Next-state, shift/subtract step and completion loading.
   always_comb begin
      state_d   = state_q;
      dq_d      = dq_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      res_d     = res_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      dbz_d     = dbz_q;
      shifted_s = {rem_q, dq_q[WIDTH-1]};
      diff_s    = shifted_s - {1'b0, dvs_q};
      ge_s      = (shifted_s >= {1'b0, dvs_q});

      case (state_q)
         S_IDLE: begin
            if (start) begin
               dq_d  = A;
               dvs_d = B;
               rem_d = {WIDTH{1'b0}};
               cnt_d = CW'(WIDTH);
               if (B != {WIDTH{1'b0}}) begin
                  state_d = S_RUN;
                  busy_d  = 1'b1;
               end else begin
                  state_d = S_DONE;
                  quo_d   = {WIDTH{1'b1}};
                  res_d   = A;
                  dbz_d   = 1'b1;
                  done_d  = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            rem_d = ge_s ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
            dq_d  = {dq_q[WIDTH-2:0], ge_s};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               quo_d   = dq_d;
               res_d   = rem_d;
               dbz_d   = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign Q           = quo_q;
   assign R           = res_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_div8.md
Name: seq_div8

Overview:
- Iterative unsigned restoring divider; the inverse arithmetic unit to the ALU's combinational multiplier (A*B -> C).
- Computes quotient Q = A / B and remainder R = A % B for WIDTH-bit operands, one quotient bit per clock.
- Sits in the ALU beside the multiplier and is driven by the ALU control with a start/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; count register width is $clog2(WIDTH)+1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- A  input  WIDTH  dividend; captured on the accepting edge.
- B  input  WIDTH  divisor; captured on the accepting edge.
- Q  output  WIDTH  quotient; registered, held until the next completion.
- R  output  WIDTH  remainder; registered, held until the next completion.
- busy  output  1  high while a division is in progress.
- done  output  1  single-cycle completion pulse.
- div_by_zero  output  1  status of the last completed operation; valid with done and held afterwards.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; Q=0, R=0, busy=0, done=0, div_by_zero=0; internal registers cleared. An operation in flight is abandoned with no done pulse.
- States:
  - IDLE: waits for start.
  - RUN: executes the shift/subtract steps.
  - DONE: presents results for one cycle.
- IDLE, start=1 at an edge:
  - Latch dividend into the shift register, divisor into the divisor register; partial remainder=0; count=WIDTH.
  - If B!=0: go to RUN and set busy=1.
  - If B==0: go to DONE.
- IDLE, start=0: stay in IDLE; outputs hold.
- RUN, each edge:
  - Shift {rem, dq} left by 1.
  - If shifted rem >= divisor: rem = rem - divisor and dq[0]=1; otherwise dq[0]=0.
  - Decrement count.
  - The comparison is done in WIDTH+1 bits so there is no overflow at divisor > 2^(WIDTH-1).
- RUN, edge where count reaches 0:
  - Go to DONE and set busy=0.
  - Load Q=dq and R=rem; set div_by_zero=0.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE with done=0.
- Divide by zero:
  - Q=all ones (8'hFF), R=A, div_by_zero=1.
  - done is asserted in the cycle after the accepting edge (latency 1 instead of WIDTH+1).
- Latency with start accepted at edge 0:
  - Normal case: busy is high in cycles 1..WIDTH; done and the new Q/R are visible in cycle WIDTH+1 (cycle 9 for WIDTH=8).
- start during RUN or DONE is ignored. It is not queued; the requester must re-assert it in IDLE.
- start held high continuously: a new operation is accepted in the first IDLE cycle after DONE, giving a back-to-back period of WIDTH+2 cycles.
- A and B may change freely after the accepting edge; the result depends only on the captured values.
- Q, R and div_by_zero change only on completion or reset, never mid-operation.

Test Plan:
- Reset, then A=7, B=3, start pulse -> busy high for 8 cycles; done in cycle 9 with Q=2, R=1, div_by_zero=0.
- A=3, B=7 -> Q=0, R=3. A=255, B=1 -> Q=255, R=0. A=255, B=255 -> Q=1, R=0. A=200, B=129 -> Q=1, R=71 (divisor MSB set).
- A=42, B=0 -> done one cycle after start; Q=8'hFF, R=42, div_by_zero=1. A following 10/4 -> Q=2, R=2, div_by_zero cleared.
- Start 100/7; pulse start with 9/9 and change A/B during RUN -> first result only: Q=14, R=2; no second done.
- Start 50/5; assert rst in cycle 4 -> outputs 0 immediately, state IDLE, no done. After release, 50/5 -> Q=10, R=0.
- start held high with A=20, B=6 -> done pulses every 10 cycles, each with Q=3, R=2.
